// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU; one quotient bit per cycle.
// Optional build macro: DIV_EARLY_OUT_EN (skip iteration when |a| < |b|).
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic             annul,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall_req,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int MSB = WIDTH - 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             qs;
  logic             rs;

  logic [WIDTH-1:0] aMag;
  logic [WIDTH-1:0] bMag;
  logic [WIDTH+1:0] remShift;
  logic [WIDTH+1:0] trial;
  logic [WIDTH:0]   remNext;
  logic [WIDTH-1:0] quoNext;
  logic [WIDTH-1:0] quoRes;
  logic [WIDTH-1:0] remRes;

  always_comb begin
    aMag = (signed_div && a[MSB]) ? -a : a;
    bMag = (signed_div && b[MSB]) ? -b : b;

    // Trial subtraction is one bit wider than the shifted remainder so the borrow is explicit.
    remShift = {rem, quo[MSB]};
    trial    = remShift - {2'b00, dvs};
    remNext  = trial[WIDTH+1] ? remShift[WIDTH:0] : trial[WIDTH:0];
    quoNext  = {quo[WIDTH-2:0], ~trial[WIDTH+1]};

    quoRes = qs ? -quoNext : quoNext;
    remRes = rs ? -remNext[WIDTH-1:0] : remNext[WIDTH-1:0];

    stall_req = ((state == IDLE) && start && !annul) || (state == RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      qs    <= 1'b0;
      rs    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !annul) begin
            qs   <= signed_div & (a[MSB] ^ b[MSB]);
            rs   <= signed_div & a[MSB];
            dvs  <= bMag;
            quo  <= aMag;
            rem  <= '0;
            busy <= 1'b1;
            if (b == '0) begin
              state <= DONE;
              done  <= 1'b1;
              lo    <= '1;
              hi    <= a;
            end
`ifdef DIV_EARLY_OUT_EN
            else if (aMag < bMag) begin
              state <= DONE;
              done  <= 1'b1;
              lo    <= '0;
              hi    <= a;
            end
`endif
            else begin
              state <= RUN;
              cnt   <= CW'(WIDTH);
            end
          end
        end
        RUN: begin
          if (annul) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            rem <= remNext;
            quo <= quoNext;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              state <= DONE;
              done  <= 1'b1;
              lo    <= quoRes;
              hi    <= remRes;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus random operands against a 64-bit arithmetic model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic        annul;
  logic [31:0] a;
  logic [31:0] b;
  logic        stall_req;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] expHi = '0;
  logic [31:0] expLo = '0;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div), .annul(annul),
    .a(a), .b(b), .stall_req(stall_req), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: 64-bit signed arithmetic truncates toward zero, remainder follows the dividend.
  task automatic refDiv(input logic [31:0] x, input logic [31:0] y, input logic s,
                        output logic [31:0] q, output logic [31:0] r, output int lat);
    longint sx, sy, mx, my;
    sx = s ? longint'($signed(x)) : longint'({32'b0, x});
    sy = s ? longint'($signed(y)) : longint'({32'b0, y});
    mx = (sx < 0) ? -sx : sx;
    my = (sy < 0) ? -sy : sy;
    lat = 33;
    if (y == 0) begin
      q = 32'hFFFF_FFFF;
      r = x;
      lat = 1;
    end else begin
      q = 32'(sx / sy);
      r = 32'(sx % sy);
`ifdef DIV_EARLY_OUT_EN
      if (mx < my) lat = 1;
`else
      if (mx < my) lat = 33;
`endif
    end
  endtask

  task automatic runOp(input string tag, input logic [31:0] x, input logic [31:0] y, input logic s);
    logic [31:0] q, r;
    int lat, cyc, stallBad;
    refDiv(x, y, s, q, r, lat);
    a = x; b = y; signed_div = s; start = 1'b1;
    #1;
    chk({tag, ".stallStart"}, 64'(stall_req), 64'd1);
    tick();
    start = 1'b0;
    a = $urandom; b = $urandom; signed_div = $urandom_range(0, 1);
    cyc = 1;
    stallBad = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (stall_req !== 1'b1 || busy !== 1'b1) stallBad++;
      tick();
      cyc++;
    end
    chk({tag, ".latency"}, 64'(cyc), 64'(lat));
    chk({tag, ".stallRun"}, 64'(stallBad), 64'd0);
    chk({tag, ".stallDone"}, 64'(stall_req), 64'd0);
    chk({tag, ".busyDone"}, 64'(busy), 64'd1);
    chk({tag, ".lo"}, 64'(lo), 64'(q));
    chk({tag, ".hi"}, 64'(hi), 64'(r));
    expLo = q;
    expHi = r;
    tick();
    chk({tag, ".donePulse"}, 64'(done), 64'd0);
    chk({tag, ".busyAfter"}, 64'(busy), 64'd0);
    chk({tag, ".holdLo"}, 64'(lo), 64'(expLo));
    chk({tag, ".holdHi"}, 64'(hi), 64'(expHi));
  endtask

  initial begin
    int doneSeen;
    logic [31:0] rx, ry;
    logic rsgn;

    rst = 1'b0; start = 1'b1; annul = 1'b0; signed_div = 1'b0; a = 32'd5; b = 32'd1;
    tick();
    tick();
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.done", 64'(done), 64'd0);
    rst = 1'b1; start = 1'b0;
    #1;
    chk("reset.stall", 64'(stall_req), 64'd0);
    chk("reset.hi", 64'(hi), 64'd0);
    chk("reset.lo", 64'(lo), 64'd0);

    runOp("divu100_7", 32'd100, 32'd7, 1'b0);
    runOp("divNeg7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
    runOp("div7_neg2", 32'd7, 32'hFFFF_FFFE, 1'b1);
    runOp("overflow", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    runOp("divZero", 32'h0000_1234, 32'd0, 1'b0);
    runOp("divZeroS", 32'hFFFF_0000, 32'd0, 1'b1);
    runOp("small3_10", 32'd3, 32'd10, 1'b0);
    runOp("smallNeg3_10", 32'hFFFF_FFFD, 32'd10, 1'b1);
    runOp("divuBig", 32'hFFFF_FFFF, 32'd1, 1'b0);

    // Annul mid-run, with a start during RUN that must be ignored.
    a = 32'd100; b = 32'd7; signed_div = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    doneSeen = 0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      if (done === 1'b1) doneSeen++;
      start = (cyc == 5);
      a = 32'd9; b = 32'd3;
      annul = (cyc == 10);
      tick();
    end
    start = 1'b0; annul = 1'b0;
    chk("annul.busy", 64'(busy), 64'd0);
    chk("annul.stall", 64'(stall_req), 64'd0);
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) doneSeen++;
      tick();
    end
    chk("annul.noDone", 64'(doneSeen), 64'd0);
    chk("annul.holdLo", 64'(lo), 64'(expLo));
    chk("annul.holdHi", 64'(hi), 64'(expHi));

    // Annul alongside start in IDLE suppresses the launch.
    a = 32'd50; b = 32'd5; start = 1'b1; annul = 1'b1;
    #1;
    chk("annulIdle.stall", 64'(stall_req), 64'd0);
    tick();
    start = 1'b0; annul = 1'b0;
    chk("annulIdle.busy", 64'(busy), 64'd0);
    doneSeen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1 || busy === 1'b1) doneSeen++;
      tick();
    end
    chk("annulIdle.noOp", 64'(doneSeen), 64'd0);

    runOp("afterAnnul", 32'd1000, 32'd33, 1'b0);

    for (int n = 0; n < 24; n++) begin
      rsgn = 1'($urandom_range(0, 1));
      rx = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      case ($urandom_range(0, 7))
        0:       ry = 32'd0;
        1:       ry = 32'($urandom_range(1, 15));
        2:       ry = 32'hFFFF_FFFF;
        3:       ry = -32'($urandom_range(1, 15));
        default: ry = $urandom;
      endcase
      runOp($sformatf("rand%0d", n), rx, ry, rsgn);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
